// File: rtl/store_rmw_ctrl.sv
// Sub-word store sequencer: read-merge-write for SB/SH, direct write for SW.
// Optional build macro MISALIGN_TRAP_EN traps misaligned SH/SW instead of forcing alignment.
module store_rmw_ctrl #(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_data,
   input  logic [1:0]  req_funct,
   output logic        done,
   output logic        err,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_MERGE, S_WR, S_RESP} state_t;

   typedef struct packed {
      logic [1:0]  funct;
      logic [1:0]  off;
      logic [31:0] data;
   } req_t;

   state_t        state, state_nxt;
   req_t          req_q;
   logic [31:0]   rdata_q;
   logic [CW-1:0] cnt;
   logic          err_q;

   logic          accept;
   logic          is_sub;
   logic          misalign;
   logic          timeout;
   logic          in_mem;
   logic [1:0]    off_in;
   logic [31:0]   data_in;
   logic [31:0]   lane_mask;
   logic [31:0]   ins_data;
   logic [31:0]   merged;

   // Decode of the incoming request: lane offset, trimmed data, trap condition.
   always_comb begin
      is_sub   = ~req_funct[1];
      off_in   = 2'b00;
      data_in  = req_data;
      misalign = 1'b0;
      case (req_funct)
         2'b00: begin
            off_in  = req_addr[1:0];
            data_in = {24'h0, req_data[7:0]};
         end
         2'b01: begin
            off_in  = {req_addr[1], 1'b0};
            data_in = {16'h0, req_data[15:0]};
         end
         default: begin
            off_in  = 2'b00;
            data_in = req_data;
         end
      endcase
`ifdef MISALIGN_TRAP_EN
      if (req_funct == 2'b01)
         misalign = req_addr[0];
      else if (req_funct[1])
         misalign = (req_addr[1:0] != 2'b00);
`else
      misalign = 1'b0;
`endif
   end

   // Byte-lane merge of the captured read word with the shifted store data.
   always_comb begin
      case (req_q.funct)
         2'b00:   lane_mask = 32'h0000_00FF << {req_q.off, 3'b000};
         2'b01:   lane_mask = 32'h0000_FFFF << {req_q.off, 3'b000};
         default: lane_mask = 32'hFFFF_FFFF;
      endcase
      ins_data = req_q.data << {req_q.off, 3'b000};
      merged   = (rdata_q & ~lane_mask) | (ins_data & lane_mask);
   end

   assign in_mem = (state == S_RD) || (state == S_WR);

   // A timeout fires on the cycle whose missing ack would bring the count to the limit.
   generate
      if (ACK_TIMEOUT == 0) begin : g_no_to
         assign timeout = 1'b0;
      end else begin : g_to
         assign timeout = ~mem_ack && (cnt == CW'(ACK_TIMEOUT - 1));
      end
   endgenerate

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      accept    = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = ~reset;
            accept    = req_valid & ~reset;
            if (accept)
               state_nxt = misalign ? S_RESP : (is_sub ? S_RD : S_WR);
         end
         S_RD: begin
            mem_rd = 1'b1;
            if (mem_ack)
               state_nxt = S_MERGE;
            else if (timeout)
               state_nxt = S_RESP;
         end
         S_MERGE: state_nxt = S_WR;
         S_WR: begin
            mem_wr = 1'b1;
            if (mem_ack || timeout)
               state_nxt = S_RESP;
         end
         S_RESP: begin
            done      = 1'b1;
            err       = err_q;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         req_q     <= '0;
         rdata_q   <= '0;
         cnt       <= '0;
         err_q     <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            req_q.funct <= req_funct;
            req_q.off   <= off_in;
            req_q.data  <= data_in;
            mem_addr    <= {req_addr[31:2], 2'b00};
            err_q       <= misalign;
            if (!is_sub)
               mem_wdata <= req_data;
         end
         // Counter only runs while a memory request is outstanding; MERGE clears it before WR.
         if (!in_mem)
            cnt <= '0;
         else if (!mem_ack)
            cnt <= cnt + CW'(1);
         if (in_mem && timeout)
            err_q <= 1'b1;
         if (state == S_RD && mem_ack)
            rdata_q <= mem_rdata;
         if (state == S_MERGE)
            mem_wdata <= merged;
      end
   end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Directed bench for store_rmw_ctrl with a cycle-stepped memory responder.
module tb_store_rmw_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic [31:0] req_data = '0;
   logic [1:0]  req_funct = '0;
   logic        done, err;
   logic [31:0] mem_addr;
   logic        mem_rd, mem_wr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;

   int checks = 0;
   int errors = 0;

   store_rmw_ctrl #(.ACK_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .req_funct(req_funct),
      .done(done), .err(err),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one store from a negedge and act as memory until done; rw/ww are
   // wait cycles before ack in RD/WR (99 = never ack).
   task automatic run_op(input string tag, input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rd, input int rw, input int ww,
                         input bit poke, input int e_dcyc, input logic e_err,
                         input int e_nrd, input int e_nwr, input logic [31:0] e_wd);
      int dcyc = -1, nrd = 0, nwr = 0, bad_addr = 0, both = 0, err_nd = 0;
      logic derr = 1'b0;
      logic [31:0] wd = '0;
      logic ack;
      chk({tag, "_ready"}, req_ready, 1'b1);
      req_valid = 1'b1; req_funct = f; req_addr = a; req_data = d;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (mem_rd && mem_wr) both++;
         if ((mem_rd || mem_wr) && mem_addr !== {a[31:2], 2'b00}) bad_addr++;
         if (!done && err) err_nd++;
         if (done) begin
            dcyc = cyc;
            derr = err;
            break;
         end
         ack = 1'b0;
         if (mem_rd) begin
            nrd++;
            if (nrd == rw + 1) ack = 1'b1;
         end
         if (mem_wr) begin
            nwr++;
            wd = mem_wdata;
            if (nwr == ww + 1) ack = 1'b1;
         end
         mem_ack = ack;
         mem_rdata = rd;
         if (poke) begin
            req_valid = (cyc == 2 || cyc == 3);
            req_funct = 2'b10; req_addr = 32'h0000_0400; req_data = 32'h5555_5555;
         end
         @(negedge clk);
      end
      mem_ack = 1'b0;
      req_valid = 1'b0;
      chk({tag, "_done_cycle"}, dcyc, e_dcyc);
      chk({tag, "_err"}, derr, e_err);
      chk({tag, "_rd_cycles"}, nrd, e_nrd);
      chk({tag, "_wr_cycles"}, nwr, e_nwr);
      chk({tag, "_rd_wr_overlap"}, both, 0);
      chk({tag, "_addr"}, bad_addr, 0);
      chk({tag, "_err_without_done"}, err_nd, 0);
      if (e_nwr != 0) chk({tag, "_wdata"}, wd, e_wd);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 1'b0);
      chk({tag, "_ready_after"}, req_ready, 1'b1);
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", req_ready, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_rd", mem_rd, 1'b0);
      chk("rst_wr", mem_wr, 1'b0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      run_op("sb_103", 2'b00, 32'h103, 32'hAB, 32'h1122_3344, 0, 0, 1'b0,
             4, 1'b0, 1, 1, 32'hAB22_3344);
      run_op("sh_202", 2'b01, 32'h202, 32'hFFFF_BEEF, 32'hDEAD_C0DE, 0, 0, 1'b0,
             4, 1'b0, 1, 1, 32'hBEEF_C0DE);
      run_op("sw_200", 2'b10, 32'h200, 32'h1234_5678, 32'h0, 0, 0, 1'b0,
             2, 1'b0, 0, 1, 32'h1234_5678);
      run_op("sb_040", 2'b00, 32'h040, 32'h1234_56C3, 32'hFFFF_FFFF, 0, 0, 1'b0,
             4, 1'b0, 1, 1, 32'hFFFF_FFC3);
      run_op("f11_044", 2'b11, 32'h044, 32'hCAFE_F00D, 32'h0, 0, 0, 1'b0,
             2, 1'b0, 0, 1, 32'hCAFE_F00D);
      // Waits; RD ack lands on the same cycle the count reaches the limit
      run_op("sb_wait", 2'b00, 32'h501, 32'h77, 32'h0, 3, 2, 1'b1,
             9, 1'b0, 4, 3, 32'h0000_7700);
      run_op("sb_tmo", 2'b00, 32'h010, 32'h99, 32'h0, 99, 99, 1'b0,
             5, 1'b1, 4, 0, 32'h0);
      run_op("sw_after_tmo", 2'b10, 32'h600, 32'hA5A5_A5A5, 32'h0, 0, 0, 1'b0,
             2, 1'b0, 0, 1, 32'hA5A5_A5A5);
`ifdef MISALIGN_TRAP_EN
      run_op("sh_301", 2'b01, 32'h301, 32'h1234_CAFE, 32'hAABB_CCDD, 0, 0, 1'b0,
             1, 1'b1, 0, 0, 32'h0);
      run_op("sw_202", 2'b10, 32'h202, 32'h1111_2222, 32'h0, 0, 0, 1'b0,
             1, 1'b1, 0, 0, 32'h0);
`else
      run_op("sh_301", 2'b01, 32'h301, 32'h1234_CAFE, 32'hAABB_CCDD, 0, 0, 1'b0,
             4, 1'b0, 1, 1, 32'hAABB_CAFE);
      run_op("sw_202", 2'b10, 32'h202, 32'h1111_2222, 32'h0, 0, 0, 1'b0,
             2, 1'b0, 0, 1, 32'h1111_2222);
`endif

      // Reset during WR
      chk("mid_ready", req_ready, 1'b1);
      req_valid = 1'b1; req_funct = 2'b00; req_addr = 32'h700; req_data = 32'h11;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("mid_rd", mem_rd, 1'b1);
      mem_ack = 1'b1; mem_rdata = 32'h0;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("mid_merge_wr", mem_wr, 1'b0);
      @(negedge clk);
      chk("mid_wr", mem_wr, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_wr", mem_wr, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_ready", req_ready, 1'b0);
      chk("mid_rst_addr", mem_addr, 32'h0);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", req_ready, 1'b1);
      chk("post_rst_done", done, 1'b0);
      chk("post_rst_wr", mem_wr, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
